// File: rtl/calc_bcd_sched.sv
// ---------------------------------------------------------------------------
// calc_bcd_sched
//   Scheduler and controller for one shared serial restoring divide-by-10
//   datapath. Two requesters are served round-robin. Each granted 8-bit
//   value is converted to three BCD digits with two 8-step divide passes.
//   Pass 1 yields the ones digit and value/10. Pass 2 yields the tens digit,
//   and its quotient is the hundreds digit.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   req0/din0  in   requester 0 request and operand (held until ack0)
//   ack0       out  one-cycle pulse after din0 was captured
//   req1/din1  in   requester 1 request and operand (held until ack1)
//   ack1       out  one-cycle pulse after din1 was captured
//   busy       out  high whenever the controller is not idle
//   out_valid  out  result available, held until out_ready
//   out_ready  in   consumer accepts the result
//   out_id     out  requester index of the current result
//   bcd_h/t/o  out  hundreds / tens / ones digits
//
// Build option
//   CALC_ZBLANK_EN : leading-zero blanking (4'hF) on the hundreds and tens
//                    digits for 7-segment drivers. The ones digit is never
//                    blanked. Undefined: raw digits only.
// ---------------------------------------------------------------------------
module calc_bcd_sched #(
  parameter int W         = 8,
  parameter int DIV_STEPS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] din0,
  output logic         ack0,
  input  logic         req1,
  input  logic [W-1:0] din1,
  output logic         ack1,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_id,
  output logic [3:0]   bcd_h,
  output logic [3:0]   bcd_t,
  output logic [3:0]   bcd_o
);

  localparam int SW = $clog2(DIV_STEPS);

  typedef enum logic [1:0] {IDLE, DIV1, DIV2, DONE} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_q;
  logic [4:0]      r_r;
  logic [SW-1:0]   r_step;
  logic [3:0]      r_ones;
  logic            r_rr_last;
  logic            r_ack0;
  logic            r_ack1;
  logic            r_out_valid;
  logic            r_out_id;
  logic [3:0]      r_bcd_h;
  logic [3:0]      r_bcd_t;
  logic [3:0]      r_bcd_o;

  logic            w_busy;
  logic            w_any_req;
  logic            w_both_req;
  logic            w_grant;
  logic [SW-1:0]   w_idx;
  logic            w_last;
  logic [4:0]      w_r_shift;
  logic [5:0]      w_step_res;
  logic [4:0]      w_r_next;
  logic [W-1:0]    w_q_next;
  logic [11:0]     w_digits;

  // One restoring step: returns {quotient bit, new remainder}. The shifted
  // remainder is at most 19, so a single conditional subtract suffices.
  function automatic logic [5:0] div_step(input logic [4:0] rem_in);
    if (rem_in >= 5'd10) begin
      return {1'b1, rem_in - 5'd10};
    end
    return {1'b0, rem_in};
  endfunction

  function automatic logic [11:0] fmt_digits(input logic [3:0] h,
                                             input logic [3:0] t,
                                             input logic [3:0] o);
`ifdef CALC_ZBLANK_EN
    logic [3:0] bh;
    logic [3:0] bt;
    bh = h;
    bt = t;
    if (h == 4'd0) begin
      bh = 4'hF;
      if (t == 4'd0) begin
        bt = 4'hF;
      end
    end
    return {bh, bt, o};
`else
    return {h, t, o};
`endif
  endfunction

  // Arbitration: a lone requester wins; on contention the one that did not
  // win the previous contention wins.
  assign w_any_req  = req0 | req1;
  assign w_both_req = req0 & req1;
  assign w_grant    = w_both_req ? ~r_rr_last : req1;

  // Divide datapath, MSB of A first.
  assign w_idx      = SW'(W - 1) - r_step;
  assign w_last     = (r_step == SW'(DIV_STEPS - 1));
  assign w_r_shift  = {r_r[3:0], r_a[w_idx]};
  assign w_step_res = div_step(w_r_shift);
  assign w_r_next   = w_step_res[4:0];

  always_comb begin
    w_q_next        = r_q;
    w_q_next[w_idx] = w_step_res[5];
  end

  // At the end of pass 2 the quotient is the hundreds digit (at most 2).
  assign w_digits = fmt_digits(w_q_next[3:0], w_r_next[3:0], r_ones);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = (r_state != IDLE);
    unique case (r_state)
      IDLE: if (w_any_req) w_next_state = DIV1;
      DIV1: if (w_last)    w_next_state = DIV2;
      DIV2: if (w_last)    w_next_state = DONE;
      DONE: if (r_out_valid && out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_step      <= '0;
      r_ones      <= '0;
      r_rr_last   <= 1'b1;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_id    <= 1'b0;
      r_bcd_h     <= '0;
      r_bcd_t     <= '0;
      r_bcd_o     <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_a      <= w_grant ? din1 : din0;
            r_q      <= '0;
            r_r      <= '0;
            r_step   <= '0;
            r_out_id <= w_grant;
            r_ack0   <= ~w_grant;
            r_ack1   <= w_grant;
            if (w_both_req) begin
              r_rr_last <= w_grant;
            end
          end
        end
        DIV1, DIV2: begin
          // The counter wraps to 0 after the last step, ready for the next pass.
          r_step <= r_step + SW'(1);
          r_q    <= w_q_next;
          r_r    <= w_r_next;
          if (w_last) begin
            if (r_state == DIV1) begin
              r_ones <= w_r_next[3:0];
              r_a    <= w_q_next;
              r_q    <= '0;
              r_r    <= '0;
            end else begin
              r_bcd_h     <= w_digits[11:8];
              r_bcd_t     <= w_digits[7:4];
              r_bcd_o     <= w_digits[3:0];
              r_out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign busy      = w_busy;
  assign out_valid = r_out_valid;
  assign out_id    = r_out_id;
  assign bcd_h     = r_bcd_h;
  assign bcd_t     = r_bcd_t;
  assign bcd_o     = r_bcd_o;

endmodule

// File: doc/calc_bcd_sched.md
Name: calc_bcd_sched

Overview:
- Scheduler and controller for one shared serial restoring divide-by-10 datapath.
- Serves two requesters with round-robin arbitration.
- Converts each granted 8-bit binary value into three BCD digits (hundreds/tens/ones) using two 8-step divide passes.
- Sits between the value producers and the digit display/packing logic.

Parameters:
- W, 8, operand width; only 8 is supported, and the three-digit output assumes it.
- DIV_STEPS, 8, divide iterations per pass; must equal W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 request; held with din0 until ack0.
- din0  in  8  requester 0 binary operand.
- ack0  out  1  one-cycle pulse: din0 captured.
- req1  in  1  requester 1 request; held with din1 until ack1.
- din1  in  8  requester 1 binary operand.
- ack1  out  1  one-cycle pulse: din1 captured.
- busy  out  1  high whenever state != IDLE.
- out_valid  out  1  result available; held until out_ready.
- out_ready  in  1  consumer accepts result.
- out_id  out  1  requester index of the current result.
- bcd_h  out  4  hundreds digit.
- bcd_t  out  4  tens digit.
- bcd_o  out  4  ones digit.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; ack0=ack1=busy=out_valid=out_id=0; bcd_h=bcd_t=bcd_o=0; rr_last=1, so req0 wins the first contention; internal A, Q, R and step counter cleared.
- Reset mid-operation: the operation is abandoned and no result or ack is produced for it.
- FSM states: IDLE, DIV1, DIV2, DONE.
- IDLE capture and ack:
  - On the edge where state=IDLE and any req is high, capture the granted din into A, clear Q/R/step, record out_id, and go to DIV1.
  - The granted ack is high for exactly the following cycle.
  - A req is ignored while busy.
- Arbitration:
  - Single request: grant that requester.
  - Both requesting: grant the requester != rr_last, then set rr_last to the winner.
- Divide step (DIV1 and DIV2, one per clock, MSB first):
  - R(5b) = {R[3:0], A[7-step]}.
  - If R>=10: Q[7-step]=1 and R=R-10; else Q[7-step]=0.
  - step increments 0..7. R never exceeds 19, so 5 bits suffice; step wraps to 0 between passes.
- DIV1 end (after step 7):
  - ones = R[3:0].
  - A = Q (quotient, max 25); Q and R cleared; go to DIV2.
- DIV2 end (after step 7):
  - tens = R[3:0]; hundreds = Q[3:0] (max 2).
  - Register bcd_h/t/o and set out_valid; go to DONE.
- Latency: out_valid rises exactly 16 clocks after the capture edge (8 DIV1 + 8 DIV2 steps).
- DONE:
  - bcd_*, out_id and out_valid are held stable until out_valid && out_ready at an edge.
  - At that edge: out_valid=0, go to IDLE. A request can be captured on the next edge at the earliest.
- Back-to-back throughput: 1 result per 18 cycles minimum (capture + 16 + handshake).
- Simultaneous events:
  - A request arriving during DONE waits; it is never lost as long as req is held.
  - out_ready while out_valid=0 has no effect.
- Boundaries:
  - din=0 gives 0/0/0.
  - din=255 gives 2/5/5.
  - din=9 gives 0/0/9.
  - din=10 gives 0/1/0.
  - din=100 gives 1/0/0.

Optional Feature:
- Macro: CALC_ZBLANK_EN (leading-zero blanking for 7-segment drivers).
- Defined:
  - bcd_h=4'hF when hundreds==0.
  - bcd_t=4'hF when hundreds==0 and tens==0.
  - bcd_o is never blanked.
  - Blanking is applied in the same register update as out_valid, so latency is unchanged.
- Undefined: raw digits are always output and no 4'hF code ever appears.

Test Plan:
- Single conversion: req0=1, din0=255, out_ready=1 → ack0 pulse 1 cycle after capture; out_valid 16 cycles after capture with bcd_h/t/o=2/5/5, out_id=0.
- Boundary values: din0 sequence 0, 9, 10, 99, 100, 200 → 0/0/0, 0/0/9, 0/1/0, 0/9/9, 1/0/0, 2/0/0, each at 16-cycle latency.
- Contention: req0 and req1 held high together, din0=37, din1=142 → order id0 (0/3/7), id1 (1/4/2), id0 (0/3/7), id1 (1/4/2)…; no ack while busy.
- Backpressure: out_ready=0 for 20 cycles after out_valid, with din=123 → outputs held at 1/2/3; busy stays high; a pending req1 is not acked until the cycle after the out_ready handshake.
- Reset mid-op: assert rst at step 5 of DIV2 → all outputs 0 asynchronously; no out_valid. After release, req1 with din1=64 → 0/6/4, out_id=1.
- CALC_ZBLANK_EN defined: din=7 → F/F/7; din=40 → F/4/0; din=0 → F/F/0; din=105 → 1/0/5.
